// File: rtl/sram_like_arbiter_2x1.sv
// Shares one SRAM-like master port between the instruction-fetch and data ports.
// Data has priority; a saturating starvation counter forces an instruction grant.
module sram_like_arbiter_2x1 #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wen,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_DATA, OWN_INST} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       inst_wins;
  logic       accept;
  logic       respond;

  assign inst_wins = inst_req && (!data_req || starve_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_DATA;
      starve_cnt <= 4'd0;
      m_req      <= 1'b0;
      m_wr       <= 1'b0;
      m_size     <= 2'd0;
      m_wen      <= 4'd0;
      m_addr     <= 32'd0;
      m_wdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_wins) begin
            owner      <= OWN_INST;
            state      <= ADDR;
            m_req      <= 1'b1;
            m_wr       <= inst_wr;
            m_size     <= inst_size;
            m_wen      <= inst_wen;
            m_addr     <= inst_addr;
            m_wdata    <= inst_wdata;
            starve_cnt <= 4'd0;
          end else if (data_req) begin
            owner      <= OWN_DATA;
            state      <= ADDR;
            m_req      <= 1'b1;
            m_wr       <= data_wr;
            m_size     <= data_size;
            m_wen      <= data_wen;
            m_addr     <= data_addr;
            m_wdata    <= data_wdata;
            // Only a data grant that leaves an instruction waiting counts.
            if (!inst_req)
              starve_cnt <= 4'd0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= 4'd0;
          end
        end
        ADDR: begin
          if (m_addr_ok) begin
            m_req <= 1'b0;
            state <= m_data_ok ? IDLE : DATA;
          end
        end
        DATA: begin
          if (m_data_ok)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshakes are forwarded combinationally to whichever port owns the bus.
  assign accept  = rst && (state == ADDR) && m_addr_ok;
  assign respond = rst && m_data_ok &&
                   (((state == ADDR) && m_addr_ok) || (state == DATA));

  assign inst_addr_ok = accept  && (owner == OWN_INST);
  assign inst_data_ok = respond && (owner == OWN_INST);
  assign data_addr_ok = accept  && (owner == OWN_DATA);
  assign data_data_ok = respond && (owner == OWN_DATA);

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

endmodule

// File: tb/tb_sram_like_arbiter_2x1.sv
// Randomized bench for sram_like_arbiter_2x1 with a transaction-level reference model.
module tb_sram_like_arbiter_2x1;

  localparam int LIMIT = 4;
  localparam logic [31:0] INST_MARK = 32'h1000_0000;
  localparam logic [31:0] DATA_MARK = 32'h1faf_f000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wen;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [3:0]  m_wen;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  sram_like_arbiter_2x1 #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wen(inst_wen),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one transaction in flight, described by who owns it,
  // whether the slave has taken its address, and the fields captured at grant.
  bit          busy, accepted, inst_owns;
  int          starve;
  logic        l_wr;
  logic [1:0]  l_size;
  logic [3:0]  l_wen;
  logic [31:0] l_addr, l_wdata;

  // Stimulus knobs (percentages, reset in per mille) and requester/slave bookkeeping.
  int p_inst, p_data, p_aok, p_dok, p_zero, p_stray, p_reset;
  bit hold_both, log_grants, prev_mreq;
  bit inst_taken, data_taken, slave_pend;
  bit grants[$];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%08h expected=%08h", tag, got, want);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic rand_inst();
    inst_wr    = ($urandom_range(0, 9) == 0);
    inst_size  = 2'($urandom_range(0, 2));
    inst_wen   = 4'($urandom);
    inst_addr  = $urandom;
    inst_wdata = $urandom;
  endtask

  task automatic rand_data();
    data_wr    = pct(50);
    data_size  = 2'($urandom_range(0, 2));
    data_wen   = 4'($urandom);
    data_addr  = $urandom;
    data_wdata = $urandom;
  endtask

  task automatic apply_stimulus();
    rst = ($urandom_range(0, 999) < p_reset) ? 1'b0 : 1'b1;
    if (hold_both) begin
      inst_req = 1'b1;
      data_req = 1'b1;
    end else begin
      // A request holds its fields until accepted; afterwards the port may change anything.
      if (!inst_req || inst_taken) begin
        rand_inst();
        inst_req = pct(p_inst);
      end
      if (!data_req || data_taken) begin
        rand_data();
        data_req = pct(p_data);
      end
    end
    m_rdata = $urandom;
    if (m_req) begin
      m_addr_ok = pct(p_aok);
      m_data_ok = m_addr_ok && pct(p_zero);
    end else if (slave_pend) begin
      m_addr_ok = pct(p_stray);
      m_data_ok = pct(p_dok);
    end else begin
      m_addr_ok = pct(p_stray);
      m_data_ok = pct(p_stray);
    end
  endtask

  task automatic compare_and_step();
    bit fa, fd;
    logic [3:0] acks;
    fa = rst && busy && !accepted && m_addr_ok;
    fd = rst && busy && (accepted || fa) && m_data_ok;
    acks = {fa && inst_owns, fd && inst_owns, fa && !inst_owns, fd && !inst_owns};
    check_output("m_req", 32'(m_req), 32'(busy && !accepted));
    check_output("m_addr", m_addr, l_addr);
    check_output("m_wdata", m_wdata, l_wdata);
    check_output("m_ctrl", 32'({m_wr, m_size, m_wen}), 32'({l_wr, l_size, l_wen}));
    check_output("acks", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'(acks));
    check_output("inst_rdata", inst_rdata, m_rdata);
    check_output("data_rdata", data_rdata, m_rdata);

    inst_taken = fa && inst_owns;
    data_taken = fa && !inst_owns;
    if (m_req && m_addr_ok && !m_data_ok) slave_pend = 1'b1;
    else if (m_data_ok) slave_pend = 1'b0;
    if (log_grants && m_req && !prev_mreq) grants.push_back(m_addr == INST_MARK);
    prev_mreq = m_req;

    // What the arbiter must do at the coming clock edge.
    if (!rst) begin
      busy = 0; accepted = 0; inst_owns = 0; starve = 0;
      l_wr = 0; l_size = 0; l_wen = 0; l_addr = 0; l_wdata = 0;
    end else if (!busy) begin
      if (inst_req && (!data_req || starve == LIMIT)) begin
        busy = 1; inst_owns = 1; starve = 0;
        l_wr = inst_wr; l_size = inst_size; l_wen = inst_wen;
        l_addr = inst_addr; l_wdata = inst_wdata;
      end else if (data_req) begin
        busy = 1; inst_owns = 0;
        starve = inst_req ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
        l_wr = data_wr; l_size = data_size; l_wen = data_wen;
        l_addr = data_addr; l_wdata = data_wdata;
      end else begin
        starve = 0;
      end
    end else if (fd) begin
      busy = 0; accepted = 0;
    end else if (fa) begin
      accepted = 1;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      apply_stimulus();
      @(negedge clk);
      compare_and_step();
    end
  endtask

  task automatic set_knobs(input int pi, input int pd, input int pa, input int pdk,
                           input int pz, input int ps, input int pr);
    p_inst = pi; p_data = pd; p_aok = pa; p_dok = pdk; p_zero = pz; p_stray = ps; p_reset = pr;
  endtask

  initial begin
    rst = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wen = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
    m_rdata = 0; m_addr_ok = 1'b1; m_data_ok = 1'b1;
    busy = 0; accepted = 0; inst_owns = 0; starve = 0;
    l_wr = 0; l_size = 0; l_wen = 0; l_addr = 0; l_wdata = 0;
    hold_both = 0; log_grants = 0; prev_mreq = 0;
    inst_taken = 0; data_taken = 0; slave_pend = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_m_req", 32'(m_req), 32'd0);
    check_output("reset_m_addr", m_addr, 32'd0);
    check_output("reset_acks", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'd0);
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
    compare_and_step();

    // Mixed traffic with slow, fast and zero-latency slave responses.
    set_knobs(30, 40, 60, 50, 20, 5, 0);
    run_cycles(800);

    // Both ports busy all the time.
    set_knobs(100, 100, 70, 60, 30, 5, 0);
    run_cycles(600);

    // Continuous contention with a 1-cycle slave: grants go D,D,D,D,I repeatedly.
    set_knobs(100, 100, 100, 100, 0, 0, 1000);
    hold_both = 1;
    inst_wr = 0; inst_size = 2; inst_wen = 4'hF; inst_addr = INST_MARK; inst_wdata = 32'h0;
    data_wr = 1; data_size = 2; data_wen = 4'hF; data_addr = DATA_MARK; data_wdata = 32'h1234_5678;
    run_cycles(2);
    p_reset = 0;
    grants.delete();
    log_grants = 1;
    run_cycles(40);
    log_grants = 0;
    hold_both = 0;
    check_output("grant_count_min10", 32'(grants.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      check_output($sformatf("grant_order_%0d", i), 32'(grants[i]), 32'((i % 5) == 4));

    // Random resets abandon transactions; the slave keeps sending late responses.
    set_knobs(30, 40, 50, 40, 20, 15, 15);
    run_cycles(1500);

    // Idle bus with stray slave handshakes only.
    set_knobs(0, 0, 50, 50, 0, 50, 0);
    run_cycles(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
